// File: rtl/gt2.sv
// gt2: 2-bit unsigned magnitude comparator with registered flags and a
// saturating greater-than event counter.
//
// Ports:
//   clk       - single clock, all state updates on its rising edge
//   reset     - synchronous, active-high
//   a, b      - 2-bit unsigned operands
//   gt_comb   - combinational a > b (unaffected by clk/reset)
//   result    - registered a > b, one clock latency
//   eq        - registered a == b
//   lt        - registered a < b
//   valid     - high once a compare of sampled inputs is held
//   gt_count  - saturating count of edges on which a > b was sampled
module gt2 #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           a,
  input  logic [1:0]           b,
  output logic                 result,
  output logic                 gt_comb,
  output logic                 eq,
  output logic                 lt,
  output logic                 valid,
  output logic [CNT_WIDTH-1:0] gt_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  assign gt_comb = (a > b);

  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      valid    <= 1'b0;
      gt_count <= '0;
    end else begin
      result <= (a > b);
      eq     <= (a == b);
      lt     <= (a < b);
      valid  <= 1'b1;
      // Hold at all-ones instead of wrapping back to zero.
      if ((a > b) && (gt_count != CNT_MAX))
        gt_count <= gt_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_gt2.sv
module tb_gt2;

  typedef struct {
    logic       res;
    logic       eq;
    logic       lt;
    logic       vld;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] a = 2'b00;
  logic [1:0] b = 2'b00;

  logic       res8, gtc8, eq8, lt8, vld8;
  logic [7:0] cnt8;
  logic       res2, gtc2, eq2, lt2, vld2;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];

  // Bench-side reference state
  logic       m_res = 1'b0;
  logic [7:0] m_c8 = 8'd0;
  logic [1:0] m_c2 = 2'd0;

  gt2 dut8 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .result(res8), .gt_comb(gtc8), .eq(eq8), .lt(lt8),
    .valid(vld8), .gt_count(cnt8)
  );

  gt2 #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .result(res2), .gt_comb(gtc2), .eq(eq2), .lt(lt2),
    .valid(vld2), .gt_count(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector for the coming edge and record what that edge must produce.
  task automatic step(input logic [1:0] va, input logic [1:0] vb, input logic vr);
    exp_t e;
    @(negedge clk);
    a = va;
    b = vb;
    reset = vr;
    if (vr) begin
      e = '{res: 1'b0, eq: 1'b0, lt: 1'b0, vld: 1'b0, c8: 8'd0, c2: 2'd0};
      m_c8 = 8'd0;
      m_c2 = 2'd0;
    end else begin
      if (va > vb) begin
        if (m_c8 != 8'hff) m_c8 = m_c8 + 8'd1;
        if (m_c2 != 2'h3) m_c2 = m_c2 + 2'd1;
      end
      e = '{res: (va > vb), eq: (va == vb), lt: (va < vb), vld: 1'b1, c8: m_c8, c2: m_c2};
    end
    m_res = e.res;
    sb.push_back(e);
    #1;
    chk("gt_comb_mid", {7'd0, gtc8}, {7'd0, (va > vb)});
  endtask

  // Monitor: every edge that has a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", {7'd0, res8}, {7'd0, e.res});
        chk("eq", {7'd0, eq8}, {7'd0, e.eq});
        chk("lt", {7'd0, lt8}, {7'd0, e.lt});
        chk("valid", {7'd0, vld8}, {7'd0, e.vld});
        chk("gt_count8", cnt8, e.c8);
        chk("gt_count2", {6'd0, cnt2}, {6'd0, e.c2});
        chk("result_w2", {7'd0, res2}, {7'd0, e.res});
        chk("valid_w2", {7'd0, vld2}, {7'd0, e.vld});
        chk("gt_comb_edge", {7'd0, gtc8}, {7'd0, (a > b)});
        if (vld8 === 1'b1)
          chk("onehot", {6'd0, 2'(res8) + 2'(eq8) + 2'(lt8)}, 8'd1);
      end
    end
  end

  initial begin
    // Reset held two edges with a > b; gt_comb stays 1 throughout.
    step(2'd3, 2'd0, 1'b1);
    step(2'd3, 2'd0, 1'b1);
    // Release: result=1, valid=1, count=1.
    step(2'd3, 2'd0, 1'b0);

    // Exhaustive sweep of all 16 pairs.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        step(2'(i), 2'(j), 1'b0);

    // Mid-cycle change: gt_comb reacts, result waits for the edge.
    step(2'd0, 2'd0, 1'b0);
    @(posedge clk);
    #3;
    a = 2'b10;
    b = 2'b01;
    #1;
    chk("gt_comb_midcycle", {7'd0, gtc8}, 8'd1);
    chk("result_holds", {7'd0, res8}, {7'd0, m_res});
    step(2'b10, 2'b01, 1'b0);

    // Saturation (width 2 reads 1,2,3,3,3).
    step(2'd3, 2'd0, 1'b1);
    for (int k = 0; k < 5; k++)
      step(2'd3, 2'd0, 1'b0);

    // Mid-run reset after count=5, counting resumes next edge.
    step(2'd3, 2'd0, 1'b1);
    step(2'd3, 2'd0, 1'b0);
    step(2'd3, 2'd0, 1'b0);

    // Hold at count=2 with equal operands.
    for (int k = 0; k < 3; k++)
      step(2'd1, 2'd1, 1'b0);
    step(2'd0, 2'd2, 1'b0);

    // Drain the scoreboard, bounded.
    for (int t = 0; t < 10 && sb.size() > 0; t++)
      @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
